// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Module : vga_timing_pkg
// Brief  : Mode timing constants and the packed timing record for the VGA
//          timing generator.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    localparam int TW = 12;

    typedef struct packed {
        logic [TW-1:0] h_vis;
        logic [TW-1:0] h_last;
        logic [TW-1:0] h_ss;
        logic [TW-1:0] h_se;
        logic [TW-1:0] v_vis;
        logic [TW-1:0] v_last;
        logic [TW-1:0] v_ss;
        logic [TW-1:0] v_se;
        logic          h_pos;
        logic          v_pos;
    } timing_t;

    // Elaboration-time only: derives last index and inclusive sync window.
    function automatic timing_t make_timing(input int hv, input int hf, input int hs, input int hb,
                                            input int vv, input int vf, input int vs, input int vb,
                                            input logic hp, input logic vp);
        timing_t t;
        t.h_vis  = TW'(hv);
        t.h_last = TW'(hv + hf + hs + hb - 1);
        t.h_ss   = TW'(hv + hf);
        t.h_se   = TW'(hv + hf + hs - 1);
        t.v_vis  = TW'(vv);
        t.v_last = TW'(vv + vf + vs + vb - 1);
        t.v_ss   = TW'(vv + vf);
        t.v_se   = TW'(vv + vf + vs - 1);
        t.h_pos  = hp;
        t.v_pos  = vp;
        return t;
    endfunction

    localparam timing_t C_MODES [4] = '{
        make_timing( 640,  16,  96,  48, 480, 10, 2, 33, 1'b0, 1'b0),
        make_timing( 800,  40, 128,  88, 600,  1, 4, 23, 1'b1, 1'b1),
        make_timing(1024,  24, 136, 160, 768,  3, 6, 29, 1'b0, 1'b0),
        make_timing(1280, 110,  40, 220, 720,  5, 5, 20, 1'b1, 1'b1)
    };

endpackage

`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
// ============================================================================
// Module : vga_timing_gen_if
// Brief  : Pixel-enable / mode request and timing outputs of the generator.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface vga_timing_gen_if #(
    parameter int CW = 12,
    parameter int MW = 2
);
    logic          P_CLK;
    logic [MW-1:0] MODE;
    logic [CW-1:0] XPOS;
    logic [CW-1:0] YPOS;
    logic          HSYNC;
    logic          VSYNC;
    logic          DISP_ACTIVE;
    logic          LINE_START;
    logic          FRAME_START;
    logic [MW-1:0] MODE_ACTIVE;

    modport master (
        input  P_CLK, MODE,
        output XPOS, YPOS, HSYNC, VSYNC, DISP_ACTIVE, LINE_START, FRAME_START, MODE_ACTIVE
    );

    modport slave (
        output P_CLK, MODE,
        input  XPOS, YPOS, HSYNC, VSYNC, DISP_ACTIVE, LINE_START, FRAME_START, MODE_ACTIVE
    );
endinterface

`default_nettype wire

// File: rtl/vga_mode_rom.sv
// ============================================================================
// Module : vga_mode_rom
// Brief  : Combinational lookup from active mode to its timing record.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vga_mode_rom
    import vga_timing_pkg::*;
#(
    parameter int MW = 2
) (
    input  wire logic [MW-1:0] i_mode,
    output timing_t            o_timing
);

    assign o_timing = C_MODES[i_mode];

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module : vga_timing_gen
// Brief  : Multi-mode VGA timing generator; counters in stage 1, registered
//          output decode in stage 2, mode switches only at frame end.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CW = 12,
    parameter int MW = 2
) (
    input  wire logic         CLK,
    input  wire logic         RST,
    vga_timing_gen_if.master  bus
);

    timing_t       w_tim;
    logic [CW-1:0] r_h;
    logic [CW-1:0] r_v;
    logic [MW-1:0] r_mode;
    logic [CW-1:0] w_h_next;
    logic [CW-1:0] w_v_next;
    logic [MW-1:0] w_mode_next;
    logic          w_h_end;
    logic          w_v_end;
    logic          w_h_vis;
    logic          w_v_vis;
    logic          w_hs_act;
    logic          w_vs_act;

    // Record always follows r_mode, so stage 2 decodes each (h,v) with its own mode.
    vga_mode_rom #(.MW(MW)) u_rom (
        .i_mode   (r_mode),
        .o_timing (w_tim)
    );

    assign w_h_end     = (r_h == CW'(w_tim.h_last));
    assign w_v_end     = (r_v == CW'(w_tim.v_last));
    assign w_h_next    = w_h_end ? '0 : r_h + CW'(1);
    assign w_v_next    = w_h_end ? (w_v_end ? '0 : r_v + CW'(1)) : r_v;
    assign w_mode_next = (w_h_end && w_v_end) ? bus.MODE : r_mode;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_h    <= '0;
            r_v    <= '0;
            r_mode <= '0;
        end else if (bus.P_CLK) begin
            r_h    <= w_h_next;
            r_v    <= w_v_next;
            r_mode <= w_mode_next;
        end
    end

    assign w_h_vis  = (r_h < CW'(w_tim.h_vis));
    assign w_v_vis  = (r_v < CW'(w_tim.v_vis));
    assign w_hs_act = (r_h >= CW'(w_tim.h_ss)) && (r_h <= CW'(w_tim.h_se));
    assign w_vs_act = (r_v >= CW'(w_tim.v_ss)) && (r_v <= CW'(w_tim.v_se));

    // Sync output equals polarity bit while in the window, its inverse outside.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.XPOS        <= '0;
            bus.YPOS        <= '0;
            bus.HSYNC       <= 1'b1;
            bus.VSYNC       <= 1'b1;
            bus.DISP_ACTIVE <= 1'b0;
            bus.LINE_START  <= 1'b0;
            bus.FRAME_START <= 1'b0;
            bus.MODE_ACTIVE <= '0;
        end else if (bus.P_CLK) begin
            bus.XPOS        <= w_h_vis ? r_h : '0;
            bus.YPOS        <= w_v_vis ? r_v : '0;
            bus.HSYNC       <= w_hs_act ~^ w_tim.h_pos;
            bus.VSYNC       <= w_vs_act ~^ w_tim.v_pos;
            bus.DISP_ACTIVE <= w_h_vis & w_v_vis;
            bus.LINE_START  <= (r_h == '0);
            bus.FRAME_START <= (r_h == '0) && (r_v == '0);
            bus.MODE_ACTIVE <= r_mode;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module : tb_vga_timing_gen
// Brief  : Scoreboard bench for vga_timing_gen; long frames are shortened by
//          forcing the stage-1 next-state nets to chosen (h,v) positions.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        hs;
        logic        vs;
        logic        da;
        logic        ls;
        logic        fs;
        logic [1:0]  ma;
    } exp_t;

    localparam exp_t RST_EXP = '{x: 12'd0, y: 12'd0, hs: 1'b1, vs: 1'b1, da: 1'b0,
                                  ls: 1'b0, fs: 1'b0, ma: 2'd0};

    int HV [4] = '{640, 800, 1024, 1280};
    int HF [4] = '{16, 40, 24, 110};
    int HS [4] = '{96, 128, 136, 40};
    int HB [4] = '{48, 88, 160, 220};
    int VV [4] = '{480, 600, 768, 720};
    int VF [4] = '{10, 1, 3, 5};
    int VS [4] = '{2, 4, 6, 5};
    int VB [4] = '{33, 23, 29, 20};
    bit HP [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    bit VP [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    logic CLK = 1'b0;
    logic RST = 1'b1;
    vga_timing_gen_if #(.CW(12), .MW(2)) bus();

    vga_timing_gen #(.CW(12), .MW(2)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    always #5 CLK = ~CLK;

    int   total = 0;
    int   bad   = 0;
    exp_t sb [$];
    exp_t last_exp = RST_EXP;
    int   m_h = 0, m_v = 0, m_mode = 0;
    bit   j_en = 1'b0;
    logic [11:0] j_h = '0, j_v = '0;

    function automatic exp_t decode(input int h, input int v, input int m);
        exp_t e;
        int   hss = HV[m] + HF[m];
        int   vss = VV[m] + VF[m];
        bit   ha  = (h >= hss) && (h < hss + HS[m]);
        bit   va  = (v >= vss) && (v < vss + VS[m]);
        e.x  = (h < HV[m]) ? 12'(h) : 12'd0;
        e.y  = (v < VV[m]) ? 12'(v) : 12'd0;
        e.hs = ha ? HP[m] : !HP[m];
        e.vs = va ? VP[m] : !VP[m];
        e.da = (h < HV[m]) && (v < VV[m]);
        e.ls = (h == 0);
        e.fs = (h == 0) && (v == 0);
        e.ma = 2'(m);
        return e;
    endfunction

    // Drive one CLK cycle; the model predicts what the outputs show after it.
    task automatic tick(input bit pen, input bit rst);
        int htot = HV[m_mode] + HF[m_mode] + HS[m_mode] + HB[m_mode];
        int vtot = VV[m_mode] + VF[m_mode] + VS[m_mode] + VB[m_mode];
        bus.P_CLK = pen;
        RST       = rst;
        if (rst) begin
            last_exp = RST_EXP;
            m_h = 0; m_v = 0; m_mode = 0;
        end else if (pen) begin
            last_exp = decode(m_h, m_v, m_mode);
            if (m_h == htot - 1 && m_v == vtot - 1) m_mode = int'(bus.MODE);
            if (j_en) begin
                m_h = int'(j_h); m_v = int'(j_v);
            end else if (m_h == htot - 1) begin
                m_h = 0;
                m_v = (m_v == vtot - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
        end
        sb.push_back(last_exp);
        @(posedge CLK);
        #1;
    endtask

    task automatic jump(input int h, input int v);
        j_h  = 12'(h);
        j_v  = 12'(v);
        j_en = 1'b1;
        force dut.w_h_next = j_h;
        force dut.w_v_next = j_v;
        tick(1'b1, 1'b0);
        release dut.w_h_next;
        release dut.w_v_next;
        j_en = 1'b0;
    endtask

    always @(posedge CLK) begin
        exp_t e;
        exp_t a;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a = '{x: bus.XPOS, y: bus.YPOS, hs: bus.HSYNC, vs: bus.VSYNC, da: bus.DISP_ACTIVE,
                  ls: bus.LINE_START, fs: bus.FRAME_START, ma: bus.MODE_ACTIVE};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL pixel_out t=%0t got x=%0d y=%0d hs=%b vs=%b da=%b ls=%b fs=%b ma=%0d want x=%0d y=%0d hs=%b vs=%b da=%b ls=%b fs=%b ma=%0d",
                         $time, a.x, a.y, a.hs, a.vs, a.da, a.ls, a.fs, a.ma,
                         e.x, e.y, e.hs, e.vs, e.da, e.ls, e.fs, e.ma);
            end
            total++;
            if ((!a.da && a.x != 0 && a.y != 0) ||
                (a.da && (a.hs === HP[a.ma] || a.vs === VP[a.ma]))) begin
                bad++;
                $display("FAIL consistency t=%0t got da=%b x=%0d y=%0d hs=%b vs=%b want blank-zero/no-sync",
                         $time, a.da, a.x, a.y, a.hs, a.vs);
            end
        end
    end

    task automatic test_reset();
        bus.MODE = 2'd0;
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        total++;
        if ({bus.XPOS, bus.YPOS, bus.HSYNC, bus.VSYNC, bus.DISP_ACTIVE, bus.LINE_START,
             bus.FRAME_START, bus.MODE_ACTIVE} !== {24'd0, 1'b1, 1'b1, 3'b000, 2'd0}) begin
            bad++;
            $display("FAIL reset_state got hs=%b vs=%b da=%b ls=%b fs=%b ma=%0d want hs=1 vs=1 da=0 ls=0 fs=0 ma=0",
                     bus.HSYNC, bus.VSYNC, bus.DISP_ACTIVE, bus.LINE_START, bus.FRAME_START, bus.MODE_ACTIVE);
        end
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        total++;
        if ({bus.FRAME_START, bus.LINE_START, bus.DISP_ACTIVE, bus.XPOS} !== {3'b111, 12'd0}) begin
            bad++;
            $display("FAIL first_pixel got fs=%b ls=%b da=%b x=%0d want fs=1 ls=1 da=1 x=0",
                     bus.FRAME_START, bus.LINE_START, bus.DISP_ACTIVE, bus.XPOS);
        end
    endtask

    task automatic test_mode0_hsync();
        int idx = 0, hs_cnt = 0, hs_first = -1, da_cnt = 1, lines = 0;
        for (int p = 0; p < 1600; p++) begin
            tick(1'b0, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
            tick(1'b1, 1'b0);
            idx++;
            if (bus.LINE_START) begin
                total++;
                if (idx != 800 || hs_cnt != 96 || hs_first != 656 || da_cnt != 640) begin
                    bad++;
                    $display("FAIL m0_line got len=%0d hs_cnt=%0d hs_first=%0d da=%0d want 800/96/656/640",
                             idx, hs_cnt, hs_first, da_cnt);
                end
                idx = 0; hs_cnt = 0; hs_first = -1; da_cnt = 0; lines++;
            end
            if (bus.DISP_ACTIVE) da_cnt++;
            if (!bus.HSYNC) begin
                if (hs_first < 0) hs_first = idx;
                hs_cnt++;
            end
        end
        total++;
        if (lines != 2) begin
            bad++;
            $display("FAIL m0_line_count got %0d want 2", lines);
        end
    endtask

    task automatic test_mode0_vsync();
        int ln = 485, vs_cnt = 0, vs_first = -1, vs_last = -1;
        jump(0, 486);
        for (int p = 0; p < 4801; p++) begin
            tick(1'b1, 1'b0);
            if (bus.LINE_START) ln++;
            if (!bus.VSYNC) begin
                if (vs_first < 0) vs_first = ln;
                vs_last = ln;
                vs_cnt++;
            end
        end
        total++;
        if (vs_first != 490 || vs_last != 491 || vs_cnt != 1600 || ln != 492) begin
            bad++;
            $display("FAIL m0_vsync got first=%0d last=%0d cnt=%0d end=%0d want 490/491/1600/492",
                     vs_first, vs_last, vs_cnt, ln);
        end
    endtask

    task automatic test_mode_switch();
        int early = 0, n = 0, len = 0, xmax = 0;
        bus.MODE = 2'd2;
        for (int p = 0; p < 800; p++) begin
            tick(1'b1, 1'b0);
            if (bus.MODE_ACTIVE !== 2'd0) early++;
        end
        total++;
        if (early != 0) begin
            bad++;
            $display("FAIL midframe_mode_ignored got %0d switched pixels want 0", early);
        end
        jump(795, 524);
        while (n < 20 && !bus.FRAME_START) begin
            tick(1'b1, 1'b0);
            n++;
        end
        total++;
        if (n != 6 || bus.MODE_ACTIVE !== 2'd2) begin
            bad++;
            $display("FAIL switch_frame_start got n=%0d ma=%0d want n=6 ma=2", n, bus.MODE_ACTIVE);
        end
        do begin
            tick(1'b1, 1'b0);
            len++;
            if (int'(bus.XPOS) > xmax) xmax = int'(bus.XPOS);
        end while (!bus.LINE_START && len < 2000);
        total++;
        if (len != 1344 || xmax != 1023) begin
            bad++;
            $display("FAIL m2_line got len=%0d xmax=%0d want 1344/1023", len, xmax);
        end
    endtask

    task automatic test_mode3();
        int n = 0, idx = 0, hf = -1, hl = -1, ln = 722, vf = -1, vl = -1, vcnt = 0;
        bus.MODE = 2'd3;
        jump(1339, 805);
        while (n < 20 && !bus.FRAME_START) begin
            tick(1'b1, 1'b0);
            n++;
        end
        total++;
        if (!bus.FRAME_START || bus.MODE_ACTIVE !== 2'd3) begin
            bad++;
            $display("FAIL m3_enter got fs=%b ma=%0d want fs=1 ma=3", bus.FRAME_START, bus.MODE_ACTIVE);
        end
        do begin
            tick(1'b1, 1'b0);
            idx++;
            if (bus.HSYNC && !bus.LINE_START) begin
                if (hf < 0) hf = idx;
                hl = idx;
            end
        end while (!bus.LINE_START && idx < 2000);
        total++;
        if (idx != 1650 || hf != 1390 || hl != 1429) begin
            bad++;
            $display("FAIL m3_hsync got len=%0d first=%0d last=%0d want 1650/1390/1429", idx, hf, hl);
        end
        jump(0, 723);
        for (int p = 0; p < 13201; p++) begin
            tick(1'b1, 1'b0);
            if (bus.LINE_START) ln++;
            if (bus.VSYNC) begin
                if (vf < 0) vf = ln;
                vl = ln;
                vcnt++;
            end
        end
        total++;
        if (vf != 725 || vl != 729 || vcnt != 8250) begin
            bad++;
            $display("FAIL m3_vsync got first=%0d last=%0d cnt=%0d want 725/729/8250", vf, vl, vcnt);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bus.MODE = 2'd1;
        jump(1649, 749);
        while (n < 20 && !bus.FRAME_START) begin
            tick(1'b1, 1'b0);
            n++;
        end
        jump(300, 200);
        tick(1'b1, 1'b0);
        total++;
        if (bus.XPOS !== 12'd300 || bus.YPOS !== 12'd200 || bus.MODE_ACTIVE !== 2'd1) begin
            bad++;
            $display("FAIL m1_position got x=%0d y=%0d ma=%0d want 300/200/1", bus.XPOS, bus.YPOS, bus.MODE_ACTIVE);
        end
        tick(1'b1, 1'b1);
        total++;
        if ({bus.XPOS, bus.YPOS, bus.HSYNC, bus.VSYNC, bus.DISP_ACTIVE, bus.LINE_START,
             bus.FRAME_START, bus.MODE_ACTIVE} !== {24'd0, 1'b1, 1'b1, 3'b000, 2'd0}) begin
            bad++;
            $display("FAIL midframe_reset got x=%0d y=%0d hs=%b vs=%b da=%b ma=%0d want 0/0/1/1/0/0",
                     bus.XPOS, bus.YPOS, bus.HSYNC, bus.VSYNC, bus.DISP_ACTIVE, bus.MODE_ACTIVE);
        end
        bus.MODE = 2'd0;
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        total++;
        if (bus.FRAME_START !== 1'b1 || bus.MODE_ACTIVE !== 2'd0) begin
            bad++;
            $display("FAIL post_reset_frame got fs=%b ma=%0d want fs=1 ma=0", bus.FRAME_START, bus.MODE_ACTIVE);
        end
    endtask

    task automatic test_pclk_hold();
        logic [11:0] sx;
        int          moved = 0;
        for (int p = 0; p < 100; p++) tick(1'b1, 1'b0);
        sx = bus.XPOS;
        for (int p = 0; p < 50; p++) begin
            tick(1'b0, 1'b0);
            if (bus.XPOS !== sx || bus.DISP_ACTIVE !== 1'b1) moved++;
        end
        total++;
        if (moved != 0 || sx !== 12'd100) begin
            bad++;
            $display("FAIL hold_frozen got moved=%0d x=%0d want 0 moves x=100", moved, sx);
        end
        tick(1'b1, 1'b0);
        total++;
        if (bus.XPOS !== sx + 12'd1) begin
            bad++;
            $display("FAIL hold_resume got x=%0d want %0d", bus.XPOS, sx + 12'd1);
        end
    endtask

    initial begin
        bus.P_CLK = 1'b0;
        bus.MODE  = 2'd0;
        test_reset();
        test_mode0_hsync();
        test_mode0_vsync();
        test_mode_switch();
        test_mode3();
        test_reset_mid();
        test_pclk_hold();
        tick(1'b0, 1'b0);
        #5;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
